// File: rtl/data_mem_controller.sv
// Data-memory sequencer for the MEM stage: sub-word loads/stores over a
// word-wide simple-dual-port RAM, plus debug word reads when the pipe is idle.
module data_mem_controller #(
    parameter int MEMORY_WIDTH = 32,
    parameter int NB_ADDR      = 7,
    parameter int NB_BYTE_ADDR = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_pipe_req,
    input  logic                    i_pipe_we,
    input  logic [1:0]              i_pipe_size,
    input  logic                    i_pipe_unsigned,
    input  logic [NB_BYTE_ADDR-1:0] i_pipe_addr,
    input  logic [MEMORY_WIDTH-1:0] i_pipe_wdata,
    output logic [MEMORY_WIDTH-1:0] o_pipe_rdata,
    output logic                    o_pipe_ack,
    output logic                    o_pipe_stall,
    output logic                    o_misaligned,
    input  logic                    i_dbg_req,
    input  logic [NB_ADDR-1:0]      i_dbg_addr,
    output logic [MEMORY_WIDTH-1:0] o_dbg_data,
    output logic                    o_dbg_valid,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic [NB_ADDR-1:0]      o_read_addr,
    output logic [NB_ADDR-1:0]      o_write_addr,
    output logic [MEMORY_WIDTH-1:0] o_write_data,
    input  logic [MEMORY_WIDTH-1:0] i_mem_data
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RMW_WRITE,
        DBG_WAIT
    } state_t;

    state_t             state;
    logic [1:0]         lat_lane;
    logic [1:0]         lat_size;
    logic               lat_unsigned;
    logic [NB_ADDR-1:0] lat_index;
    logic [15:0]        lat_wdata;

    logic [NB_ADDR-1:0] pipe_index;
    logic               pipe_misaligned;
    logic               word_store;
    logic               dbg_go;
    logic [4:0]         lane_shift;
    logic [31:0]        ld_shift;
    logic [31:0]        ld_value;
    logic [31:0]        lane_mask;
    logic [31:0]        merged;
    logic               unused_addr;

    assign pipe_index  = i_pipe_addr[NB_ADDR+1:2];
    assign unused_addr = ^i_pipe_addr[NB_BYTE_ADDR-1:NB_ADDR+2];
    assign word_store  = i_pipe_we & (i_pipe_size == 2'b10);
    // Block re-issue while the previous dump word is still being presented.
    assign dbg_go      = i_dbg_req & ~i_pipe_req & ~o_dbg_valid;

    always_comb begin
        unique case (i_pipe_size)
            2'b00:   pipe_misaligned = 1'b0;
            2'b01:   pipe_misaligned = i_pipe_addr[0];
            2'b10:   pipe_misaligned = |i_pipe_addr[1:0];
            default: pipe_misaligned = 1'b1;
        endcase
    end

    assign lane_shift = {lat_lane, 3'b000};
    assign ld_shift   = i_mem_data >> lane_shift;

    always_comb begin
        unique case (lat_size)
            2'b00: ld_value = lat_unsigned ? {24'd0, ld_shift[7:0]}
                                           : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01: ld_value = lat_unsigned ? {16'd0, ld_shift[15:0]}
                                           : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_value = i_mem_data;
        endcase
    end

    assign lane_mask = ((lat_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)
                       << lane_shift;
    assign merged = (i_mem_data & ~lane_mask)
                  | (({16'd0, lat_wdata} << lane_shift) & lane_mask);

    always_comb begin
        o_pipe_rdata = '0;
        o_pipe_ack   = 1'b0;
        o_misaligned = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_read_addr  = '0;
        o_write_addr = '0;
        o_write_data = '0;
        unique case (state)
            IDLE: begin
                if (i_pipe_req) begin
                    if (pipe_misaligned) begin
                        o_pipe_ack   = 1'b1;
                        o_misaligned = 1'b1;
                    end else if (word_store) begin
                        o_mem_write  = 1'b1;
                        o_write_addr = pipe_index;
                        o_write_data = i_pipe_wdata;
                        o_pipe_ack   = 1'b1;
                    end else begin
                        o_mem_read  = 1'b1;
                        o_read_addr = pipe_index;
                    end
                end else if (dbg_go) begin
                    o_mem_read  = 1'b1;
                    o_read_addr = i_dbg_addr;
                end
            end
            LOAD_WAIT: begin
                o_pipe_ack   = 1'b1;
                o_pipe_rdata = ld_value;
            end
            RMW_WRITE: begin
                o_mem_write  = 1'b1;
                o_write_addr = lat_index;
                o_write_data = merged;
                o_pipe_ack   = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_pipe_stall = i_pipe_req & ~o_pipe_ack;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            lat_lane     <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_index    <= '0;
            lat_wdata    <= '0;
            o_dbg_data   <= '0;
            o_dbg_valid  <= 1'b0;
        end else begin
            o_dbg_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_pipe_req) begin
                        if (!pipe_misaligned && !word_store) begin
                            lat_lane     <= i_pipe_addr[1:0];
                            lat_size     <= i_pipe_size;
                            lat_unsigned <= i_pipe_unsigned;
                            lat_index    <= pipe_index;
                            lat_wdata    <= i_pipe_wdata[15:0];
                            state        <= i_pipe_we ? RMW_WRITE : LOAD_WAIT;
                        end
                    end else if (dbg_go) begin
                        state <= DBG_WAIT;
                    end
                end
                DBG_WAIT: begin
                    o_dbg_data  <= i_mem_data;
                    o_dbg_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
